// File: rtl/perf_pkg.sv
// Shared types for the performance-counter dump block.
// FSM state, event index type and a last-record helper.
package perf_pkg;

  localparam int PERF_IDX_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dump_state_t;

  typedef logic [PERF_IDX_W-1:0] perf_idx_t;

  function automatic logic perf_is_last(
    input perf_idx_t   idx,
    input int unsigned num
  );
    return idx == perf_idx_t'(num - 1);
  endfunction

endpackage

// File: rtl/perf_counter_sat.sv
// One saturating event counter with synchronous clear
// and a sticky overflow flag.
module perf_counter_sat #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_ovf
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic                 w_sat;

  assign w_sat = &r_cnt;
  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

  // clear wins over an increment in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_inc) begin
      if (w_sat) r_ovf <= 1'b1;
      else       r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/perf_dump_ctrl.sv
// Event counter bank with snapshot-and-stream dump,
// triggered by request or by a periodic auto timer.
module perf_dump_ctrl
  import perf_pkg::*;
#(
  parameter int EVENT_NUM = 8,
  parameter int CNT_WIDTH = 32,
  parameter int INTERVAL  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [EVENT_NUM-1:0]         events,
  input  logic                         clear,
  input  logic                         dump_req,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(EVENT_NUM)-1:0] out_id,
  output logic [CNT_WIDTH-1:0]         out_value,
  output logic                         out_last,
  output logic [EVENT_NUM-1:0]         overflow
);

  localparam int ID_W = $clog2(EVENT_NUM);

  logic [EVENT_NUM-1:0][CNT_WIDTH-1:0] w_cnt;
  logic [EVENT_NUM-1:0][CNT_WIDTH-1:0] r_shadow;
  dump_state_t                         r_state;
  dump_state_t                         w_state_nxt;
  logic [ID_W-1:0]                     r_id;
  logic                                r_pend;
  logic                                w_auto;
  logic                                w_trig;
  logic                                w_hs;
  logic                                w_last;

  for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cnt
    perf_counter_sat #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_clear(clear),
      .i_inc  (events[g]),
      .o_cnt  (w_cnt[g]),
      .o_ovf  (overflow[g])
    );
  end

  if (INTERVAL > 0) begin : g_ivl
    localparam int IVL_W = $clog2(INTERVAL + 1);
    localparam logic [IVL_W-1:0] IVL_END =
      IVL_W'(INTERVAL - 1);

    logic [IVL_W-1:0] r_ivl;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_ivl <= '0;
      else if (r_ivl == IVL_END) r_ivl <= '0;
      else                      r_ivl <= r_ivl + 1'b1;
    end

    assign w_auto = (r_ivl == IVL_END);
  end else begin : g_no_ivl
    assign w_auto = 1'b0;
  end

  assign out_valid = (r_state == SEND);
  assign busy      = out_valid;
  assign out_id    = r_id;
  assign w_last    = perf_is_last(perf_idx_t'(r_id),
                                  EVENT_NUM);
  assign out_last  = out_valid && w_last;
  assign out_value = out_valid ? r_shadow[r_id] : '0;
  assign w_hs      = out_valid && out_ready;
  assign w_trig    = (r_state == IDLE) &&
                     (dump_req || w_auto || r_pend);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_trig)          w_state_nxt = SEND;
      SEND:    if (w_hs && w_last)  w_state_nxt = IDLE;
      default:                      w_state_nxt = IDLE;
    endcase
  end

  // shadow takes pre-edge counter values; pending
  // auto trigger is only recorded while streaming
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_id     <= '0;
      r_pend   <= 1'b0;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_trig) begin
        r_shadow <= w_cnt;
        r_id     <= '0;
      end else if (w_hs) begin
        r_id <= w_last ? '0 : r_id + 1'b1;
      end
      if (r_state == IDLE) r_pend <= 1'b0;
      else if (w_auto)     r_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_perf_dump_ctrl.sv
// Randomized scoreboard bench for perf_dump_ctrl with a
// cycle-level reference model of counters and dump traffic.
module tb_perf_dump_ctrl;

  localparam int N    = 8;
  localparam int W    = 4;
  localparam int IV   = 20;
  localparam int IDW  = 3;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   events;
  logic           clear;
  logic           dump_req;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [IDW-1:0] out_id;
  logic [W-1:0]   out_value;
  logic           out_last;
  logic [N-1:0]   overflow;

  always #5 clk = ~clk;

  perf_dump_ctrl #(
    .EVENT_NUM(N),
    .CNT_WIDTH(W),
    .INTERVAL (IV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .events   (events),
    .clear    (clear),
    .dump_req (dump_req),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_id   (out_id),
    .out_value(out_value),
    .out_last (out_last),
    .overflow (overflow)
  );

  typedef struct {
    int id;
    int val;
    bit last;
  } rec_t;

  rec_t exp_q[$];
  int   mcnt[N];
  bit   movf[N];
  int   rem;
  int   cyc;
  bit   mpend;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  // reference model: dump = N queued records, one retired
  // per ready cycle; auto timer = cycle count modulo IV
  always @(posedge clk or posedge rst) begin
    bit auto_f;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        mcnt[i] = 0;
        movf[i] = 1'b0;
      end
      rem   = 0;
      cyc   = 0;
      mpend = 1'b0;
      exp_q.delete();
    end else begin
      auto_f = (cyc % IV) == IV - 1;
      cyc++;
      if (rem == 0 && (dump_req || auto_f || mpend)) begin
        for (int i = 0; i < N; i++)
          exp_q.push_back('{id: i, val: mcnt[i],
                            last: (i == N - 1)});
        rem   = N;
        mpend = 1'b0;
      end else if (rem > 0) begin
        if (out_ready) rem--;
        if (auto_f) mpend = 1'b1;
      end
      if (clear) begin
        for (int i = 0; i < N; i++) begin
          mcnt[i] = 0;
          movf[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < N; i++)
          if (events[i]) begin
            if (mcnt[i] == MAXV) movf[i] = 1'b1;
            else                 mcnt[i]++;
          end
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] ov;
    rec_t         r;
    if (mon_en) begin
      for (int i = 0; i < N; i++) ov[i] = movf[i];
      chk("busy", 64'(busy), 64'(rem > 0));
      chk("out_valid", 64'(out_valid), 64'(rem > 0));
      chk("overflow", 64'(overflow), 64'(ov));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_record: got id %0d expected none",
                   out_id);
        end else begin
          r = exp_q[0];
          chk("out_id", 64'(out_id), 64'(r.id));
          chk("out_value", 64'(out_value), 64'(r.val));
          chk("out_last", 64'(out_last), 64'(r.last));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input logic [N-1:0] ev,
                      input logic clr,
                      input logic req,
                      input logic rdy);
    events    = ev;
    clear     = clr;
    dump_req  = req;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      tick('0, 1'b0, 1'b0, 1'b1);
      k++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle: got busy 1 expected 0");
    end
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    events    = '0;
    clear     = 1'b0;
    dump_req  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_id", 64'(out_id), 64'(0));
    chk("rst_value", 64'(out_value), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    rst    = 1'b0;
    mon_en = 1'b1;

    // stalled auto dump: second auto fires mid-stream
    repeat (50) tick('0, 1'b0, 1'b0, 1'b0);
    repeat (30) tick('0, 1'b0, 1'b0, 1'b1);

    // single event counted five times
    wait_idle();
    tick('0, 1'b1, 1'b0, 1'b1);
    repeat (5) tick(N'(8), 1'b0, 1'b0, 1'b1);
    tick('0, 1'b0, 1'b1, 1'b1);
    repeat (12) tick('0, 1'b0, 1'b0, 1'b1);

    // event coincident with the trigger
    wait_idle();
    tick('0, 1'b1, 1'b0, 1'b1);
    repeat (2) tick(N'(2), 1'b0, 1'b0, 1'b1);
    tick(N'(2), 1'b0, 1'b1, 1'b1);
    repeat (12) tick('0, 1'b0, 1'b0, 1'b1);

    // alternating backpressure
    wait_idle();
    tick('0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      tick('0, 1'b0, 1'b0, 1'(i % 2));

    // saturation and clear
    wait_idle();
    tick('0, 1'b1, 1'b0, 1'b1);
    repeat (17) tick(N'(1), 1'b0, 1'b0, 1'b1);
    chk("sat_ovf0", 64'(overflow[0]), 64'(1));
    tick('0, 1'b1, 1'b0, 1'b1);
    chk("clr_ovf", 64'(overflow), 64'(0));

    // reset in the middle of a stream
    wait_idle();
    tick(N'(8'h5a), 1'b0, 1'b1, 1'b1);
    k = 0;
    while (!(out_valid && out_id == IDW'(4)) && k < 40) begin
      tick('0, 1'b0, 1'b0, 1'b1);
      k++;
    end
    chk("reach_id4", 64'(out_id), 64'(4));
    rst = 1'b1;
    #2;
    chk("abort_valid", 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick('0, 1'b0, 1'b0, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    tick('0, 1'b0, 1'b1, 1'b1);
    repeat (12) tick('0, 1'b0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 1500; i++)
      tick(N'($urandom),
           ($urandom % 40) == 0,
           ($urandom % 6) == 0,
           ($urandom % 4) != 0);

    wait_idle();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
